// File: rtl/rv_ctrl_slice.sv
// Control slice of the RV32I pipeline: fetch PC incrementer, ID-stage decoder
// producing the 27-bit control bundle, and the EX/MEM control register.
module rv_ctrl_slice #(
  parameter int PC_W   = 32,
  parameter int PC_INC = 4
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [PC_W-1:0] pc_cur,
  output logic [PC_W-1:0] pc_next,
  input  logic [31:0]     instr,
  output logic [26:0]     id_ctrl,
  input  logic [26:0]     ex_ctrl,
  output logic [26:0]     mem_ctrl
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] SRC_RS2  = 3'b000;
  localparam logic [2:0] SRC_IIMM = 3'b001;
  localparam logic [2:0] SRC_SIMM = 3'b010;
  localparam logic [2:0] SRC_UIMM = 3'b011;
  localparam logic [2:0] SRC_BIMM = 3'b100;
  localparam logic [2:0] SRC_JIMM = 3'b101;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  assign pc_next = pc_cur + PC_STEP;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt_bit;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign alt_bit = instr[30];

  logic       load_instr, rf_enable, ram_enable, ram_rw, ram_se;
  logic       jalr_flag, jal_flag, auipc_flag;
  logic [2:0] shift_imm;
  logic [3:0] alu_op;
  logic [1:0] ram_size;
  logic [3:0] alu_funct;

  // Shared funct3 -> ALU mapping; the caller decides whether instr[30] may pick SUB.
  always_comb begin
    alu_funct = ALU_ADD;
    unique case (funct3)
      3'b000: alu_funct = ALU_ADD;
      3'b001: alu_funct = ALU_SLL;
      3'b010: alu_funct = ALU_SLT;
      3'b011: alu_funct = ALU_SLTU;
      3'b100: alu_funct = ALU_XOR;
      3'b101: alu_funct = alt_bit ? ALU_SRA : ALU_SRL;
      3'b110: alu_funct = ALU_OR;
      3'b111: alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  always_comb begin
    load_instr = 1'b0;
    rf_enable  = 1'b0;
    ram_enable = 1'b0;
    ram_rw     = 1'b0;
    ram_se     = 1'b0;
    jalr_flag  = 1'b0;
    jal_flag   = 1'b0;
    auipc_flag = 1'b0;
    shift_imm  = SRC_RS2;
    alu_op     = ALU_ADD;
    ram_size   = 2'b00;
    unique case (opcode)
      OPC_OP: begin
        rf_enable = 1'b1;
        shift_imm = SRC_RS2;
        alu_op    = (funct3 == 3'b000 && alt_bit) ? ALU_SUB : alu_funct;
      end
      OPC_OP_IMM: begin
        rf_enable = 1'b1;
        shift_imm = SRC_IIMM;
        alu_op    = alu_funct;
      end
      OPC_LOAD: begin
        load_instr = 1'b1;
        rf_enable  = 1'b1;
        ram_enable = 1'b1;
        shift_imm  = SRC_IIMM;
        ram_size   = funct3[1:0];
        ram_se     = ~funct3[2];
      end
      OPC_STORE: begin
        ram_enable = 1'b1;
        ram_rw     = 1'b1;
        shift_imm  = SRC_SIMM;
        ram_size   = funct3[1:0];
      end
      OPC_BRANCH: begin
        shift_imm = SRC_BIMM;
        alu_op    = ALU_SUB;
      end
      OPC_LUI: begin
        rf_enable = 1'b1;
        shift_imm = SRC_UIMM;
        alu_op    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        rf_enable  = 1'b1;
        auipc_flag = 1'b1;
        shift_imm  = SRC_UIMM;
      end
      OPC_JAL: begin
        rf_enable = 1'b1;
        jal_flag  = 1'b1;
        shift_imm = SRC_JIMM;
      end
      OPC_JALR: begin
        rf_enable = 1'b1;
        jalr_flag = 1'b1;
        shift_imm = SRC_IIMM;
      end
      default: ;
    endcase
  end

  // An all-zero instruction decodes as an unknown opcode with zero funct bits, giving a zero bundle.
  assign id_ctrl = {load_instr, rf_enable, ram_enable, ram_rw,
                    ram_se, jalr_flag, jal_flag, auipc_flag,
                    shift_imm, alu_op, ram_size, opcode, funct3};

  logic [26:0] mem_ctrl_d, mem_ctrl_q;

  always_comb begin
    mem_ctrl_d = ex_ctrl;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) mem_ctrl_q <= '0;
    else        mem_ctrl_q <= mem_ctrl_d;
  end

  assign mem_ctrl = mem_ctrl_q;

endmodule

// File: tb/tb_rv_ctrl_slice.sv
// Bench for rv_ctrl_slice: table-driven PC/decoder vectors plus a scoreboard
// for the EX/MEM register, including async reset corner cases.
module tb_rv_ctrl_slice;

  logic        clk;
  logic        Reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [26:0] id_ctrl;
  logic [26:0] ex_ctrl;
  logic [26:0] mem_ctrl;

  int checks = 0;
  int errors = 0;

  logic [26:0] exp_q[$];

  rv_ctrl_slice #(.PC_W(32), .PC_INC(4)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .pc_cur   (pc_cur),
    .pc_next  (pc_next),
    .instr    (instr),
    .id_ctrl  (id_ctrl),
    .ex_ctrl  (ex_ctrl),
    .mem_ctrl (mem_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_exp;
    logic [31:0] ins;
    logic [26:0] ctrl_exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Drive one bundle into EX/MEM and compare what comes out after the edge.
  task automatic mem_txn(input logic [26:0] v);
    logic [26:0] e;
    @(negedge clk);
    ex_ctrl = v;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL mem_q_empty got=%h exp=none", mem_ctrl);
    end else begin
      e = exp_q.pop_front();
      check("mem_ctrl", {5'b0, mem_ctrl}, {5'b0, e});
      $display("txn mem ex_ctrl=%h mem_ctrl=%h", v, mem_ctrl);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h00000000, 32'h00000004, 32'h00500093, 27'h2010098}; // addi
    vecs[1]  = '{32'hFFFFFFFC, 32'h00000000, 32'h0000A103, 27'h741081A}; // lw, pc wrap
    vecs[2]  = '{32'hFFFFFFFE, 32'h00000002, 32'h0020A223, 27'h182091A}; // sw
    vecs[3]  = '{32'h00001000, 32'h00001004, 32'h00000000, 27'h0000000}; // bubble
    vecs[4]  = '{32'h7FFFFFFC, 32'h80000000, 32'h003100B3, 27'h2000198}; // add
    vecs[5]  = '{32'h00000010, 32'h00000014, 32'h403100B3, 27'h2001198}; // sub
    vecs[6]  = '{32'h12345678, 32'h1234567C, 32'h403150B3, 27'h200719D}; // sra
    vecs[7]  = '{32'hFFFFFFFF, 32'h00000003, 32'h4030D093, 27'h201709D}; // srai
    vecs[8]  = '{32'h00000100, 32'h00000104, 32'h40008093, 27'h2010098}; // addi, instr[30]=1
    vecs[9]  = '{32'h00000200, 32'h00000204, 32'h0000C103, 27'h701001C}; // lbu
    vecs[10] = '{32'h00000300, 32'h00000304, 32'h00009103, 27'h7410419}; // lh
    vecs[11] = '{32'h00000400, 32'h00000404, 32'h00208463, 27'h0041318}; // beq
    vecs[12] = '{32'h00000500, 32'h00000504, 32'h123450B7, 27'h203A1BD}; // lui
    vecs[13] = '{32'h00000600, 32'h00000604, 32'h00000097, 27'h20B00B8}; // auipc
    vecs[14] = '{32'h00000700, 32'h00000704, 32'h008000EF, 27'h2150378}; // jal
    vecs[15] = '{32'h00000800, 32'h00000804, 32'h000080E7, 27'h2210338}; // jalr
    vecs[16] = '{32'h00000900, 32'h00000904, 32'h0000707F, 27'h00003FF}; // unknown opcode
    vecs[17] = '{32'h00000A00, 32'h00000A04, 32'h003160B3, 27'h200319E}; // or
    vecs[18] = '{32'h00000B00, 32'h00000B04, 32'h0FF0F093, 27'h201209F}; // andi
    vecs[19] = '{32'h00000C00, 32'h00000C04, 32'h003130B3, 27'h200919B}; // sltu

    Reset   = 1'b0;
    pc_cur  = '0;
    instr   = '0;
    ex_ctrl = 27'h5A5A5A5;
    #3;
    check("mem_reset_state", {5'b0, mem_ctrl}, 32'h0);

    // Decoder and adder must work while reset is held.
    pc_cur = vecs[0].pc;
    instr  = vecs[0].ins;
    #1;
    check("id_during_reset", {5'b0, id_ctrl}, {5'b0, vecs[0].ctrl_exp});
    check("pc_during_reset", pc_next, vecs[0].pc_exp);
    @(posedge clk);
    #1;
    check("mem_held_in_reset", {5'b0, mem_ctrl}, 32'h0);

    @(negedge clk);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      pc_cur = vecs[i].pc;
      instr  = vecs[i].ins;
      #1;
      check($sformatf("pc_next[%0d]", i), pc_next, vecs[i].pc_exp);
      check($sformatf("id_ctrl[%0d]", i), {5'b0, id_ctrl}, {5'b0, vecs[i].ctrl_exp});
      $display("txn vec %0d pc=%h pc_next=%h instr=%h id_ctrl=%h",
               i, pc_cur, pc_next, instr, id_ctrl);
    end

    foreach (vecs[i]) mem_txn(vecs[i].ctrl_exp);
    for (int k = 0; k < 8; k++) mem_txn(27'($urandom));

    // Async assert between edges clears the register at once.
    mem_txn(27'h7FFFFFF);
    #2;
    Reset = 1'b0;
    #1;
    check("mem_async_clear", {5'b0, mem_ctrl}, 32'h0);
    $display("txn async reset mem_ctrl=%h", mem_ctrl);
    ex_ctrl = 27'h1234567;
    @(posedge clk);
    #1;
    check("mem_reset_held_edge", {5'b0, mem_ctrl}, 32'h0);

    // Release between edges: the next edge captures ex_ctrl.
    @(negedge clk);
    Reset = 1'b1;
    #1;
    check("mem_after_release", {5'b0, mem_ctrl}, 32'h0);
    mem_txn(27'h741081A);
    mem_txn(27'h182091A);
    mem_txn(27'h0000000);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
